// File: rtl/decoder.sv
//------------------------------------------------------------------------------
// Module   : decoder
// Purpose  : Action decoder for the reinforcement-learning datapath. Converts
//            the 4-bit action index chosen by the max-select stage into fifteen
//            registered, mutually exclusive enable strobes. Action 0 means
//            "no action" and asserts no strobe.
// Ports    : clk         rising-edge clock for all state
//            rst_n       asynchronous active-low reset, clears all strobes
//            at[3:0]     action index, sampled on every rising clk edge
//            en1..en15   registered strobes; enK high iff last sampled at == K
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] at,
  output logic       en1,
  output logic       en2,
  output logic       en3,
  output logic       en4,
  output logic       en5,
  output logic       en6,
  output logic       en7,
  output logic       en8,
  output logic       en9,
  output logic       en10,
  output logic       en11,
  output logic       en12,
  output logic       en13,
  output logic       en14,
  output logic       en15
);

  // Bit K-1 of the strobe register drives enK.
  logic [14:0] strobe_d;
  logic [14:0] strobe_q;

  // Positional decode, every value listed explicitly. Action 0 and any
  // index containing X/Z fall through to the all-zero default, so the
  // register can never load an unknown or multi-hot pattern.
  always_comb begin
    strobe_d = 15'h0000;
    case (at)
      4'd1:    strobe_d = 15'h0001;
      4'd2:    strobe_d = 15'h0002;
      4'd3:    strobe_d = 15'h0004;
      4'd4:    strobe_d = 15'h0008;
      4'd5:    strobe_d = 15'h0010;
      4'd6:    strobe_d = 15'h0020;
      4'd7:    strobe_d = 15'h0040;
      4'd8:    strobe_d = 15'h0080;
      4'd9:    strobe_d = 15'h0100;
      4'd10:   strobe_d = 15'h0200;
      4'd11:   strobe_d = 15'h0400;
      4'd12:   strobe_d = 15'h0800;
      4'd13:   strobe_d = 15'h1000;
      4'd14:   strobe_d = 15'h2000;
      4'd15:   strobe_d = 15'h4000;
      default: strobe_d = 15'h0000;
    endcase
  end

  // No enable or hold: a fresh decode is captured every cycle, so a constant
  // index keeps its strobe high continuously rather than pulsing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q <= 15'h0000;
    end else begin
      strobe_q <= strobe_d;
    end
  end

  assign en1  = strobe_q[0];
  assign en2  = strobe_q[1];
  assign en3  = strobe_q[2];
  assign en4  = strobe_q[3];
  assign en5  = strobe_q[4];
  assign en6  = strobe_q[5];
  assign en7  = strobe_q[6];
  assign en8  = strobe_q[7];
  assign en9  = strobe_q[8];
  assign en10 = strobe_q[9];
  assign en11 = strobe_q[10];
  assign en12 = strobe_q[11];
  assign en13 = strobe_q[12];
  assign en14 = strobe_q[13];
  assign en15 = strobe_q[14];

endmodule

`default_nettype wire

// File: tb/tb_decoder.sv
//------------------------------------------------------------------------------
// Module   : tb_decoder
// Purpose  : Directed self-checking bench for the action decoder.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_decoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] at;
  logic       en1, en2, en3, en4, en5, en6, en7, en8;
  logic       en9, en10, en11, en12, en13, en14, en15;
  logic [14:0] en_vec;

  int n_vec;
  int n_err;

  decoder u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .at   (at),
    .en1  (en1),
    .en2  (en2),
    .en3  (en3),
    .en4  (en4),
    .en5  (en5),
    .en6  (en6),
    .en7  (en7),
    .en8  (en8),
    .en9  (en9),
    .en10 (en10),
    .en11 (en11),
    .en12 (en12),
    .en13 (en13),
    .en14 (en14),
    .en15 (en15)
  );

  assign en_vec = {en15, en14, en13, en12, en11, en10, en9, en8,
                   en7, en6, en5, en4, en3, en2, en1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven at falling edges; outputs sampled at falling edges.
  task automatic test_reset();
    rst_n = 1'b0;
    at    = 4'd5;
    #1;
    n_vec++;
    if (en_vec !== 15'h0000) begin
      n_err++;
      $display("FAIL reset_async got=%h want=%h", en_vec, 15'h0000);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (en_vec !== 15'h0000) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, en_vec, 15'h0000);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (en_vec !== 15'h0010) begin
      n_err++;
      $display("FAIL reset_release got=%h want=%h", en_vec, 15'h0010);
    end
  endtask

  task automatic test_sequence();
    logic [3:0]  seq_at [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
    logic [14:0] seq_ex [4] = '{15'h0001, 15'h0002, 15'h0004, 15'h0008};
    for (int i = 0; i < 4; i++) begin
      at = seq_at[i];
      @(negedge clk);
      n_vec++;
      if (en_vec !== seq_ex[i]) begin
        n_err++;
        $display("FAIL sequence at=%0d got=%h want=%h", seq_at[i], en_vec, seq_ex[i]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [14:0] sweep_ex [16] = '{
      15'h0000, 15'h0001, 15'h0002, 15'h0004, 15'h0008, 15'h0010,
      15'h0020, 15'h0040, 15'h0080, 15'h0100, 15'h0200, 15'h0400,
      15'h0800, 15'h1000, 15'h2000, 15'h4000};
    for (int i = 0; i < 16; i++) begin
      at = 4'(i);
      @(negedge clk);
      n_vec++;
      if (en_vec !== sweep_ex[i]) begin
        n_err++;
        $display("FAIL sweep at=%0d got=%h want=%h", i, en_vec, sweep_ex[i]);
      end
      n_vec++;
      if (!$onehot0(en_vec)) begin
        n_err++;
        $display("FAIL onehot0 at=%0d got=%h want=one-hot-or-zero", i, en_vec);
      end
    end
  endtask

  task automatic test_hold();
    at = 4'd15;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (en_vec !== 15'h4000) begin
        n_err++;
        $display("FAIL hold15 cyc=%0d got=%h want=%h", i, en_vec, 15'h4000);
      end
    end
    at = 4'd0;
    @(negedge clk);
    n_vec++;
    if (en_vec !== 15'h0000) begin
      n_err++;
      $display("FAIL hold_to_zero got=%h want=%h", en_vec, 15'h0000);
    end
  endtask

  task automatic test_mid_reset();
    at = 4'd7;
    @(negedge clk);
    n_vec++;
    if (en_vec !== 15'h0040) begin
      n_err++;
      $display("FAIL midrst_pre got=%h want=%h", en_vec, 15'h0040);
    end
    // Pulse reset low entirely between two rising edges.
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if (en_vec !== 15'h0000) begin
      n_err++;
      $display("FAIL midrst_async got=%h want=%h", en_vec, 15'h0000);
    end
    #1 rst_n = 1'b1;
    #1;
    n_vec++;
    if (en_vec !== 15'h0000) begin
      n_err++;
      $display("FAIL midrst_no_edge got=%h want=%h", en_vec, 15'h0000);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (en_vec !== 15'h0040) begin
      n_err++;
      $display("FAIL midrst_recover got=%h want=%h", en_vec, 15'h0040);
    end
    @(negedge clk);
  endtask

  task automatic test_latency();
    at = 4'd3;
    @(posedge clk);
    #1 at = 4'd9;
    #1;
    n_vec++;
    if (en_vec !== 15'h0004) begin
      n_err++;
      $display("FAIL latency_hold_early got=%h want=%h", en_vec, 15'h0004);
    end
    @(negedge clk);
    n_vec++;
    if (en_vec !== 15'h0004) begin
      n_err++;
      $display("FAIL latency_hold_mid got=%h want=%h", en_vec, 15'h0004);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (en_vec !== 15'h0100) begin
      n_err++;
      $display("FAIL latency_switch got=%h want=%h", en_vec, 15'h0100);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    // Alternate between the two boundary strobes every cycle.
    logic [3:0]  b_at [4] = '{4'd15, 4'd1, 4'd15, 4'd0};
    logic [14:0] b_ex [4] = '{15'h4000, 15'h0001, 15'h4000, 15'h0000};
    for (int i = 0; i < 4; i++) begin
      at = b_at[i];
      @(negedge clk);
      n_vec++;
      if (en_vec !== b_ex[i]) begin
        n_err++;
        $display("FAIL back_to_back at=%0d got=%h want=%h", b_at[i], en_vec, b_ex[i]);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    at    = 4'd0;
    @(negedge clk);
    test_reset();
    test_sequence();
    test_sweep();
    test_hold();
    test_mid_reset();
    test_latency();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
